// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between axil_cmd_master and its slave (axil_dpmem).
// The master modport drives AW/W/AR valids, payloads and B/R readies; the slave modport is the mirror.
interface axil_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();
    logic              AW_VALID;
    logic              AW_READY;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              W_VALID;
    logic              W_READY;
    logic [DATA_W-1:0] W_DATA;
    logic [STRB_W-1:0] W_STRB;
    logic              B_VALID;
    logic              B_READY;
    logic [1:0]        B_RESP;
    logic              AR_VALID;
    logic              AR_READY;
    logic [ADDR_W-1:0] AR_ADDR;
    logic              R_VALID;
    logic              R_READY;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;

    modport master (
        output AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
        output AR_VALID, AR_ADDR, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP,
        input  AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
        input  AR_VALID, AR_ADDR, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP,
        output AR_READY, R_VALID, R_DATA, R_RESP
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI-Lite transaction out, one response back.
// Define AXIL_MST_TIMEOUT_EN to add a per-wait watchdog that ends a stalled transaction with SLVERR.
module axil_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STRB_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    axil_cmd_master_if.master axi
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] RSP     = 3'd5;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end
    if (STRB_W * 8 != DATA_W) begin : g_bad_strb
        $error("axil_cmd_master: STRB_W must equal DATA_W/8");
    end

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [1:0]        rsp_resp_q;
    logic              wd_fire;

    // Every output below is a function of registers only, so no input reaches an output combinationally.
    assign cmd_ready    = (state == IDLE);
    assign rsp_valid    = (state == RSP);
    assign rsp_write    = rsp_write_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_resp     = rsp_resp_q;

    assign axi.AW_VALID = (state == WR_REQ) && !aw_done;
    assign axi.W_VALID  = (state == WR_REQ) && !w_done;
    assign axi.B_READY  = (state == WR_RESP);
    assign axi.AR_VALID = (state == RD_REQ);
    assign axi.R_READY  = (state == RD_DATA);
    assign axi.AW_ADDR  = addr_q;
    assign axi.AR_ADDR  = addr_q;
    assign axi.W_DATA   = wdata_q;
    assign axi.W_STRB   = wstrb_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cmd_hs, rsp_hs;
    assign aw_hs  = axi.AW_VALID && axi.AW_READY;
    assign w_hs   = axi.W_VALID  && axi.W_READY;
    assign b_hs   = axi.B_READY  && axi.B_VALID;
    assign ar_hs  = axi.AR_VALID && axi.AR_READY;
    assign r_hs   = axi.R_READY  && axi.R_VALID;
    assign cmd_hs = cmd_valid && cmd_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_hs) state_next = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                // Either channel may finish first; leave as soon as the last one handshakes.
                if (wd_fire)                                        state_next = RSP;
                else if ((aw_done || aw_hs) && (w_done || w_hs))    state_next = WR_RESP;
            end
            WR_RESP: begin
                if (wd_fire || b_hs) state_next = RSP;
            end
            RD_REQ: begin
                if (wd_fire)    state_next = RSP;
                else if (ar_hs) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (wd_fire || r_hs) state_next = RSP;
            end
            RSP: begin
                if (rsp_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (ARESET) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        rsp_write_q <= cmd_write;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_hs) begin
                        rsp_resp_q  <= axi.B_RESP;
                        rsp_rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rsp_resp_q  <= axi.R_RESP;
                        rsp_rdata_q <= axi.R_DATA;
                    end
                end
                default: ;
            endcase
            // A watchdog expiry never coincides with a handshake, so it cannot fight the captures above.
            if (wd_fire) begin
                rsp_resp_q  <= RESP_SLVERR;
                rsp_rdata_q <= '0;
            end
        end
    end

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_busy;
    logic             any_hs;
    logic             rsp_timeout_q;

    assign wd_busy = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);
    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign wd_fire = wd_busy && !any_hs && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restart the count on every state entry and on every handshake, so the limit applies per slave wait.
    always_ff @(posedge ACLK) begin
        if (ARESET || !wd_busy || any_hs || (state_next != state)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || cmd_hs) begin
            rsp_timeout_q <= 1'b0;
        end else if (wd_fire) begin
            rsp_timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign wd_fire     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small behavioural AXI-Lite memory slave.
// Build with AXIL_MST_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES is 8 here).
module tb_axil_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_write;
    logic        cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int tests = 0;
    int fails = 0;

    axil_cmd_master_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) axi ();

    axil_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .axi(axi)
    );

    always #5 ACLK = ~ACLK;

    // Behavioural slave: combinational READYs from knobs, registered B/R, word memory on addr[5:2].
    logic        aw_ready_en, w_ready_en, ar_ready_en, r_hold;
    logic [1:0]  resp_code;
    logic        s_b_valid, s_r_valid, s_r_pend, aw_got, w_got;
    logic [1:0]  s_b_resp, s_r_resp;
    logic [31:0] s_r_data, aw_a, w_d;
    logic [3:0]  w_s;
    int          b_count;
    logic [31:0] mem [0:15];

    assign axi.AW_READY = aw_ready_en;
    assign axi.W_READY  = w_ready_en;
    assign axi.AR_READY = ar_ready_en;
    assign axi.B_VALID  = s_b_valid;
    assign axi.B_RESP   = s_b_resp;
    assign axi.R_VALID  = s_r_valid;
    assign axi.R_DATA   = s_r_data;
    assign axi.R_RESP   = s_r_resp;

    wire        s_aw_hs = axi.AW_VALID && axi.AW_READY;
    wire        s_w_hs  = axi.W_VALID && axi.W_READY;
    wire        s_ar_hs = axi.AR_VALID && axi.AR_READY;
    wire [31:0] eff_a   = s_aw_hs ? axi.AW_ADDR : aw_a;
    wire [31:0] eff_d   = s_w_hs ? axi.W_DATA : w_d;
    wire [3:0]  eff_s   = s_w_hs ? axi.W_STRB : w_s;
    wire [3:0]  eff_idx = eff_a[5:2];
    wire [31:0] ar_a    = axi.AR_ADDR;
    wire [3:0]  ar_idx  = ar_a[5:2];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge ACLK) begin
        if (ARESET) begin
            s_b_valid <= 1'b0; s_r_valid <= 1'b0; s_r_pend <= 1'b0;
            aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (s_aw_hs) begin aw_got <= 1'b1; aw_a <= axi.AW_ADDR; end
            if (s_w_hs)  begin w_got <= 1'b1; w_d <= axi.W_DATA; w_s <= axi.W_STRB; end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !s_b_valid) begin
                mem[eff_idx] <= merge(mem[eff_idx], eff_d, eff_s);
                s_b_valid <= 1'b1; s_b_resp <= resp_code;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (s_b_valid && axi.B_READY) begin
                s_b_valid <= 1'b0; b_count <= b_count + 1;
            end
            if (s_ar_hs) begin
                s_r_data <= mem[ar_idx]; s_r_resp <= resp_code;
                if (r_hold) s_r_pend <= 1'b1; else s_r_valid <= 1'b1;
            end
            if (s_r_pend && !r_hold) begin s_r_pend <= 1'b0; s_r_valid <= 1'b1; end
            if (s_r_valid && axi.R_READY) s_r_valid <= 1'b0;
        end
    end

    // ---------------- stimulus helpers (no comparisons inside) ----------------
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            else @(negedge ACLK);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic [1:0] rs,
                          output logic rw, output logic seen);
        issue(w, a, d, s);
        wait_rsp(40, seen);
        rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
        if (seen) consume();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        tests++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_timeout} !== 4'b1000 ||
            rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            fails++;
            $display("FAIL reset_cmd_rsp: cmd_ready=%b rsp_valid=%b rdata=%h resp=%b, want 1 0 0 0",
                     cmd_ready, rsp_valid, rsp_rdata, rsp_resp);
        end
        tests++;
        if ({axi.AW_VALID, axi.W_VALID, axi.B_READY, axi.AR_VALID, axi.R_READY} !== 5'b0 ||
            axi.AW_ADDR !== 32'h0 || axi.W_DATA !== 32'h0 || axi.W_STRB !== 4'h0) begin
            fails++;
            $display("FAIL reset_axi: valids/readies=%b aw_addr=%h w_data=%h, want all 0",
                     {axi.AW_VALID, axi.W_VALID, axi.B_READY, axi.AR_VALID, axi.R_READY},
                     axi.AW_ADDR, axi.W_DATA);
        end
        ARESET = 1'b0;
    endtask

    task automatic test_write_read();
        logic seen;
        issue(1'b1, 32'h8, 32'hdeadbeef, 4'hF);
        tests++;
        if ({axi.AW_VALID, axi.W_VALID, cmd_ready} !== 3'b110 || axi.AW_ADDR !== 32'h8 ||
            axi.W_DATA !== 32'hdeadbeef || axi.W_STRB !== 4'hF) begin
            fails++;
            $display("FAIL wr_n1_request: aw/w/cmd_ready=%b addr=%h data=%h strb=%h, want 110 8 deadbeef f",
                     {axi.AW_VALID, axi.W_VALID, cmd_ready}, axi.AW_ADDR, axi.W_DATA, axi.W_STRB);
        end
        @(negedge ACLK);
        tests++;
        if ({axi.AW_VALID, axi.W_VALID, axi.B_READY, rsp_valid} !== 4'b0010) begin
            fails++;
            $display("FAIL wr_n2_bready: aw/w/bready/rsp=%b, want 0010",
                     {axi.AW_VALID, axi.W_VALID, axi.B_READY, rsp_valid});
        end
        @(negedge ACLK);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_resp !== 2'b00 ||
            rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0 || axi.B_READY !== 1'b0) begin
            fails++;
            $display("FAIL wr_n3_rsp: valid=%b write=%b resp=%b rdata=%h tmo=%b, want 1 1 00 0 0",
                     rsp_valid, rsp_write, rsp_resp, rsp_rdata, rsp_timeout);
        end
        consume();

        issue(1'b0, 32'h8, 32'h0, 4'h0);
        tests++;
        if (axi.AR_VALID !== 1'b1 || axi.AR_ADDR !== 32'h8) begin
            fails++;
            $display("FAIL rd_n1_ar: ar_valid=%b ar_addr=%h, want 1 8", axi.AR_VALID, axi.AR_ADDR);
        end
        @(negedge ACLK);
        tests++;
        if ({axi.AR_VALID, axi.R_READY, rsp_valid} !== 3'b010) begin
            fails++;
            $display("FAIL rd_n2_rready: ar/rready/rsp=%b, want 010",
                     {axi.AR_VALID, axi.R_READY, rsp_valid});
        end
        @(negedge ACLK);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hdeadbeef ||
            rsp_resp !== 2'b00) begin
            fails++;
            $display("FAIL rd_n3_rsp: valid=%b write=%b rdata=%h resp=%b, want 1 0 deadbeef 00",
                     rsp_valid, rsp_write, rsp_rdata, rsp_resp);
        end
        wait_rsp(1, seen);
        consume();
    endtask

    task automatic test_strobes_and_resp();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rw, seen;
        do_txn(1'b1, 32'h8, 32'h12dead34, 4'hF, rd, rs, rw, seen);
        do_txn(1'b1, 32'h8, 32'hfedcba98, 4'hC, rd, rs, rw, seen);
        do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'hfedcad34 || rs !== 2'b00) begin
            fails++;
            $display("FAIL strb_upper: seen=%b rdata=%h resp=%b, want fedcad34 00", seen, rd, rs);
        end
        do_txn(1'b1, 32'h8, 32'h55555678, 4'h3, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'h0 || rw !== 1'b1) begin
            fails++;
            $display("FAIL wr_after_rd_rdata: rdata=%h write=%b, want 0 1", rd, rw);
        end
        do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'hfedc5678) begin
            fails++;
            $display("FAIL strb_lower: rdata=%h, want fedc5678", rd);
        end
        resp_code = 2'b10;
        do_txn(1'b1, 32'h8, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rs !== 2'b10 || rd !== 32'h0) begin
            fails++;
            $display("FAIL bresp_capture: resp=%b rdata=%h, want 10 0", rs, rd);
        end
        resp_code = 2'b11;
        do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rs !== 2'b11 || rd !== 32'hfedc5678) begin
            fails++;
            $display("FAIL rresp_capture: resp=%b rdata=%h, want 11 fedc5678", rs, rd);
        end
        resp_code = 2'b00;
    endtask

    task automatic test_split_handshake();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rw, seen;
        int          b_before;
        b_before = b_count;
        aw_ready_en = 1'b0;
        issue(1'b1, 32'hC, 32'h0badf00d, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            tests++;
            if (axi.W_VALID !== 1'b0 || axi.AW_VALID !== 1'b1 || axi.AW_ADDR !== 32'hC) begin
                fails++;
                $display("FAIL w_first_hold[%0d]: w_valid=%b aw_valid=%b aw_addr=%h, want 0 1 c",
                         k, axi.W_VALID, axi.AW_VALID, axi.AW_ADDR);
            end
        end
        aw_ready_en = 1'b1;
        wait_rsp(20, seen);
        tests++;
        if (!seen || rsp_resp !== 2'b00) begin
            fails++;
            $display("FAIL w_first_rsp: seen=%b resp=%b, want 1 00", seen, rsp_resp);
        end
        if (seen) consume();
        repeat (3) @(negedge ACLK);
        tests++;
        if (b_count !== b_before + 1) begin
            fails++;
            $display("FAIL w_first_one_b: b handshakes=%0d, want %0d", b_count - b_before, 1);
        end
        do_txn(1'b0, 32'hC, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'h0badf00d) begin
            fails++;
            $display("FAIL w_first_data: rdata=%h, want 0badf00d", rd);
        end

        w_ready_en = 1'b0;
        issue(1'b1, 32'h10, 32'hcafe0001, 4'hF);
        @(negedge ACLK);
        tests++;
        if (axi.AW_VALID !== 1'b0 || axi.W_VALID !== 1'b1 || axi.W_DATA !== 32'hcafe0001) begin
            fails++;
            $display("FAIL aw_first_hold: aw_valid=%b w_valid=%b w_data=%h, want 0 1 cafe0001",
                     axi.AW_VALID, axi.W_VALID, axi.W_DATA);
        end
        w_ready_en = 1'b1;
        wait_rsp(20, seen);
        if (seen) consume();
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'hcafe0001) begin
            fails++;
            $display("FAIL aw_first_data: rdata=%h, want cafe0001", rd);
        end
    endtask

    task automatic test_rsp_backpressure();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rw, seen;
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        wait_rsp(20, seen);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h14;
        cmd_wdata = 32'h13572468; cmd_wstrb = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hfedc5678 || cmd_ready !== 1'b0 ||
                axi.AW_VALID !== 1'b0) begin
                fails++;
                $display("FAIL rsp_hold[%0d]: valid=%b rdata=%h cmd_ready=%b aw_valid=%b, want 1 fedc5678 0 0",
                         k, rsp_valid, rsp_rdata, cmd_ready, axi.AW_VALID);
            end
            @(negedge ACLK);
        end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || axi.AW_VALID !== 1'b0) begin
            fails++;
            $display("FAIL rsp_release: cmd_ready=%b rsp_valid=%b aw_valid=%b, want 1 0 0",
                     cmd_ready, rsp_valid, axi.AW_VALID);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        tests++;
        if (axi.AW_VALID !== 1'b1 || axi.AW_ADDR !== 32'h14) begin
            fails++;
            $display("FAIL pending_cmd_accept: aw_valid=%b aw_addr=%h, want 1 14",
                     axi.AW_VALID, axi.AW_ADDR);
        end
        wait_rsp(20, seen);
        if (seen) consume();
        do_txn(1'b0, 32'h14, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'h13572468) begin
            fails++;
            $display("FAIL pending_cmd_data: rdata=%h, want 13572468", rd);
        end
        rsp_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_rsp_ready: rsp_valid=%b cmd_ready=%b, want 0 1", rsp_valid, cmd_ready);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rw, seen;
        r_hold = 1'b1;
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        @(negedge ACLK);
        tests++;
        if (axi.R_READY !== 1'b1) begin
            fails++;
            $display("FAIL rd_data_state: r_ready=%b, want 1", axi.R_READY);
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        r_hold = 1'b0;
        tests++;
        if ({axi.AW_VALID, axi.W_VALID, axi.B_READY, axi.AR_VALID, axi.R_READY} !== 5'b0 ||
            axi.AR_ADDR !== 32'h0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_read: axi=%b ar_addr=%h cmd_ready=%b rsp_valid=%b, want 0 0 1 0",
                     {axi.AW_VALID, axi.W_VALID, axi.B_READY, axi.AR_VALID, axi.R_READY},
                     axi.AR_ADDR, cmd_ready, rsp_valid);
        end
        do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, rs, rw, seen);
        tests++;
        if (!seen || rd !== 32'hfedc5678 || rs !== 2'b00) begin
            fails++;
            $display("FAIL read_after_reset: seen=%b rdata=%h resp=%b, want 1 fedc5678 00", seen, rd, rs);
        end
    endtask

`ifdef AXIL_MST_TIMEOUT_EN
    task automatic test_timeout();
        ar_ready_en = 1'b0;
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (axi.AR_VALID !== 1'b1 || rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait[%0d]: ar_valid=%b rsp_valid=%b, want 1 0",
                         k, axi.AR_VALID, rsp_valid);
            end
            @(negedge ACLK);
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_timeout !== 1'b1 ||
            axi.AR_VALID !== 1'b0 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL timeout_fire: valid=%b resp=%b tmo=%b ar_valid=%b rdata=%h, want 1 10 1 0 0",
                     rsp_valid, rsp_resp, rsp_timeout, axi.AR_VALID, rsp_rdata);
        end
        consume();
        ar_ready_en = 1'b1;
    endtask
`endif

    initial begin
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_ready_en = 1'b1; w_ready_en = 1'b1; ar_ready_en = 1'b1;
        r_hold = 1'b0; resp_code = 2'b00; b_count = 0;
        test_reset();
        test_write_read();
        test_strobes_and_resp();
        test_split_handshake();
        test_rsp_backpressure();
        test_reset_mid_read();
`ifdef AXIL_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that converts a simple valid/ready command interface into AXI-Lite write (AW/W/B) or read (AR/R) transactions.
- Sits directly upstream of axil_dpmem and drives its slave modport.
- Returns one response per command: read data plus RESP code.
- Used by higher-level test sequencers and control logic to access the dual-port memory.

Parameters:
ADDR_W, 32, width of command and AXI address
DATA_W, 32, width of data buses
STRB_W, DATA_W/8, write strobe width
TIMEOUT_CYCLES, 256, watchdog limit per slave wait; used only with AXIL_MST_TIMEOUT_EN

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address, forwarded unmodified
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  STRB_W  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  2  captured B_RESP/R_RESP
rsp_timeout  out  1  watchdog fired; constant 0 without macro
AW_VALID, AW_ADDR(ADDR_W), W_VALID, W_DATA(DATA_W), W_STRB(STRB_W), B_READY, AR_VALID, AR_ADDR(ADDR_W), R_READY  out  master-driven AXI-Lite signals
AW_READY, W_READY, B_VALID, B_RESP(2), AR_READY, R_VALID, R_DATA(DATA_W), R_RESP(2)  in  slave-driven AXI-Lite signals

Behaviour:
- Reset: state=IDLE. All outputs 0 except cmd_ready=1. All AXI address/data registers 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1 in IDLE only.
  - On cmd_valid&&cmd_ready, register cmd_* and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
- WR_REQ:
  - AW_VALID and W_VALID both assert in the cycle after acceptance.
  - Each deasserts independently the cycle after its own handshake (VALID&&READY).
  - aw_done and w_done flags track completion. Either order or simultaneous completion is legal.
  - When both flags are set, go to WR_RESP.
  - AW_ADDR/W_DATA/W_STRB hold stable while the corresponding VALID is high.
- WR_RESP: B_READY=1. On B_VALID, capture B_RESP, set rsp_rdata=0, go to RSP.
- RD_REQ: AR_VALID=1 until AR_READY, then go to RD_DATA. AR_ADDR holds stable.
- RD_DATA: R_READY=1. On R_VALID, capture R_DATA/R_RESP, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* hold stable until rsp_ready.
  - On handshake, go to IDLE.
  - No command is accepted in the same cycle (cmd_ready stays 0).
- Latency with a zero-wait slave, command accepted at edge N:
  - Write: AW/W handshake at N+1, B at N+2, rsp_valid at N+3.
  - Read: AR at N+1, R at N+2, rsp_valid at N+3.
- VALID never depends combinationally on READY. No combinational path exists from any input to any output.
- Slave READY asserted before VALID is tolerated and ignored.
- rsp_ready held high in IDLE has no effect.
- ARESET mid-transaction: abandon immediately and return to reset values next cycle. The slave must be reset in the same cycle.
- Strictly one transaction outstanding. No reordering.

Optional Feature:
- Macro AXIL_MST_TIMEOUT_EN.
- When defined:
  - A counter runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - It clears on every state entry and on every AXI handshake.
  - On reaching TIMEOUT_CYCLES, drop all AXI VALID/READY and go to RSP with rsp_resp=2'b10 (SLVERR), rsp_timeout=1, rsp_rdata=0.
- When undefined: no counter, the FSM waits indefinitely, and rsp_timeout is tied 0.

Test Plan:
1. Write addr 0x8, data 0xdeadbeef, strb 0xF, slave ready always -> AW/W handshake at N+1, rsp_valid at N+3 with rsp_write=1 and rsp_resp=0; a following read of 0x8 returns rsp_rdata=0xdeadbeef.
2. Write 0xfedcba98 with strb 0xC over 0x12dead34 preload, then read 0x8 -> rsp_rdata=0xfedc_be34? No: expected 0xfedcad34 (upper two bytes replaced); rsp_resp=0.
3. W_READY asserted 3 cycles before AW_READY -> W_VALID drops after its handshake, AW_VALID holds with stable address until AW_READY, exactly one B accepted.
4. rsp_ready held low 5 cycles after a read -> rsp_valid and rsp_rdata hold stable, cmd_ready stays 0, and a new cmd_valid is not accepted until after the rsp handshake.
5. ARESET asserted while in RD_DATA -> next cycle all AXI outputs are 0, cmd_ready=1, rsp_valid=0; a subsequent read completes normally.
6. With AXIL_MST_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never asserts AR_READY -> after 8 cycles in RD_REQ, rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1, AR_VALID=0.
